ofs_plat_axi_mem_rd_arb2: RTL and testbench
===========================================

OFS_PLAT_AXI_MEM_RD_ARB2 -- requirements
Module: ofs_plat_axi_mem_rd_arb2

Interface
REQ-001 SHALL have parameter ID_W, default 4, source-side AXI read ID width.
REQ-002 SHALL have parameter AR_W, default 64, width of AR payload excluding ID.
REQ-003 SHALL have parameter R_W, default 514, width of R payload excluding ID and last.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16, per-source limit on outstanding read bursts.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports srcN_arvalid/srcN_arready  input/output  1  AR handshake, source N (N=0,1).
REQ-008 SHALL have ports srcN_arid  input  ID_W, and srcN_ar  input  AR_W, carrying the source N request.
REQ-009 SHALL have ports srcN_rvalid/srcN_rlast  output  1, and srcN_rready  input  1, forming the source N R channel.
REQ-010 SHALL have ports srcN_rid  output  ID_W, and srcN_r  output  R_W, carrying the source N response.
REQ-011 SHALL have ports sink_arvalid  output  1, sink_arready  input  1, sink_arid  output  ID_W+1, and sink_ar  output  AR_W.
REQ-012 SHALL have ports sink_rvalid/sink_rlast  input  1, sink_rready  output  1, sink_rid  input  ID_W+1, and sink_r  input  R_W.
REQ-013 SHALL have ports stat_grantsN  output  32  count of AR grants to source N.

Function
REQ-014 SHALL drive sink AR from a one-entry output register; accepted request appears on sink_arvalid exactly 1 cycle after the source handshake.
REQ-015 SHALL load the register when empty or when sink_arready=1 in the same cycle (full throughput, back-to-back).
REQ-016 SHALL hold sink_arvalid and payload stable until sink_arready=1.
REQ-017 SHALL set sink_arid = {N, srcN_arid} for the granted source N.
REQ-018 SHALL grant round-robin: with both eligible, grant the source not granted last; with one eligible, grant it.
REQ-019 SHALL update the last-grant pointer only on a completed source AR handshake.
REQ-020 SHALL define source N eligible iff srcN_arvalid=1 and outstanding_N < MAX_OUTSTANDING.
REQ-021 SHALL assert srcN_arready only for the granted, eligible source when the output register can load; never both sources in the same cycle.
REQ-022 SHALL keep per-source counter outstanding_N, width $clog2(MAX_OUTSTANDING+1): +1 on srcN AR handshake, -1 on srcN R handshake with rlast=1, unchanged when both occur in the same cycle.
REQ-023 SHALL route R combinationally (zero latency): srcN_rvalid = sink_rvalid and sink_rid[ID_W]==N; srcN_rid = sink_rid[ID_W-1:0]; srcN_r/rlast = sink_r/rlast.
REQ-024 SHALL drive sink_rready = srcN_rready of the source selected by sink_rid[ID_W].
REQ-025 SHALL not reorder or buffer R beats.

Reset
REQ-026 SHALL on reset_n=0 asynchronously clear sink_arvalid, both outstanding counters, both stat counters, and set the last-grant pointer to 1 so source 0 wins first.
REQ-027 SHALL hold srcN_arready=0 while reset_n=0; transactions in flight at reset are discarded.

Configuration
REQ-028 SHALL with macro OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN defined increment stat_grantsN on every srcN AR handshake, saturating at 32'hFFFF_FFFF.
REQ-029 SHALL with OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN undefined tie stat_grantsN to 0 and instantiate no counter logic.

Verification
REQ-030 Both sources valid continuously, sink_arready=1 -> grants alternate 0,1,0,1; sink_arid MSB alternates; one sink AR per cycle after 1-cycle latency.
REQ-031 sink_arready=0 for 5 cycles with register full -> sink_arvalid/payload stable, both srcN_arready=0; first accepted after release.
REQ-032 MAX_OUTSTANDING=2, source 0 issues 2 ARs, no R -> src0_arready=0 while source 1 still granted; one R beat with rlast=1 for source 0 -> source 0 eligible next cycle.
REQ-033 Sink R beat rid={1,4'h3}, rlast=1, src1_rready=0 then 1 -> src1_rvalid=1 with rid=4'h3, sink_rready follows src1_rready, src0_rvalid=0.
REQ-034 Same-cycle AR handshake and rlast R handshake on source 0 at outstanding_0=1 -> counter stays 1.
REQ-035 With STATS_EN, 10 source-0 grants then reset_n pulsed low mid-burst -> stat_grants0=10 before reset, 0 and sink_arvalid=0 immediately on reset assertion.

Source files
------------

// File: rtl/ofs_plat_axi_mem_rd_arb2.sv
// Two-source AXI read-address arbiter with combinational R-channel return routing.
// Source N tags its requests with sink_arid = {N, srcN_arid}. R beats are steered
// back using the tag bit. Each source is limited to MAX_OUTSTANDING open bursts.
// Optional grant statistics: define OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN.
module ofs_plat_axi_mem_rd_arb2 #(
  parameter int unsigned ID_W            = 4,
  parameter int unsigned AR_W            = 64,
  parameter int unsigned R_W             = 514,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic            clk,
  input  logic            reset_n,

  input  logic            src0_arvalid,
  output logic            src0_arready,
  input  logic [ID_W-1:0] src0_arid,
  input  logic [AR_W-1:0] src0_ar,
  output logic            src0_rvalid,
  output logic            src0_rlast,
  input  logic            src0_rready,
  output logic [ID_W-1:0] src0_rid,
  output logic [R_W-1:0]  src0_r,

  input  logic            src1_arvalid,
  output logic            src1_arready,
  input  logic [ID_W-1:0] src1_arid,
  input  logic [AR_W-1:0] src1_ar,
  output logic            src1_rvalid,
  output logic            src1_rlast,
  input  logic            src1_rready,
  output logic [ID_W-1:0] src1_rid,
  output logic [R_W-1:0]  src1_r,

  output logic            sink_arvalid,
  input  logic            sink_arready,
  output logic [ID_W:0]   sink_arid,
  output logic [AR_W-1:0] sink_ar,
  input  logic            sink_rvalid,
  input  logic            sink_rlast,
  output logic            sink_rready,
  input  logic [ID_W:0]   sink_rid,
  input  logic [R_W-1:0]  sink_r,

  output logic [31:0]     stat_grants0,
  output logic [31:0]     stat_grants1
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic             r_ar_valid;
  logic [ID_W:0]    r_ar_id;
  logic [AR_W-1:0]  r_ar;
  logic             r_last;       // 1 means source 1 was granted last
  logic [CNT_W-1:0] r_out0, r_out1;
  logic [CNT_W-1:0] w_out0_d, w_out1_d;

  logic w_can_load, w_elig0, w_elig1, w_gnt0, w_gnt1, w_hs0, w_hs1;
  logic w_rsel, w_rdone0, w_rdone1;

  // Arbitration: output register can take a new request when empty or draining.
  assign w_can_load   = ~r_ar_valid | sink_arready;
  assign w_elig0      = src0_arvalid & (r_out0 < MAX_CNT);
  assign w_elig1      = src1_arvalid & (r_out1 < MAX_CNT);
  assign w_gnt0       = w_elig0 & (~w_elig1 | r_last);
  assign w_gnt1       = w_elig1 & (~w_elig0 | ~r_last);
  // reset_n gating keeps arready low for the whole reset window.
  assign src0_arready = reset_n & w_can_load & w_gnt0;
  assign src1_arready = reset_n & w_can_load & w_gnt1;
  assign w_hs0        = src0_arvalid & src0_arready;
  assign w_hs1        = src1_arvalid & src1_arready;

  assign sink_arvalid = r_ar_valid;
  assign sink_arid    = r_ar_id;
  assign sink_ar      = r_ar;

  // R channel: pure steering on the tag bit, no storage.
  assign w_rsel      = sink_rid[ID_W];
  assign src0_rvalid = sink_rvalid & ~w_rsel;
  assign src1_rvalid = sink_rvalid & w_rsel;
  assign src0_rid    = sink_rid[ID_W-1:0];
  assign src1_rid    = sink_rid[ID_W-1:0];
  assign src0_r      = sink_r;
  assign src1_r      = sink_r;
  assign src0_rlast  = sink_rlast;
  assign src1_rlast  = sink_rlast;
  assign sink_rready = w_rsel ? src1_rready : src0_rready;
  assign w_rdone0    = sink_rvalid & sink_rready & sink_rlast & ~w_rsel;
  assign w_rdone1    = sink_rvalid & sink_rready & sink_rlast & w_rsel;

  // Sink AR output register: load on grant, otherwise empty once accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ar_valid <= 1'b0;
      r_ar_id    <= '0;
      r_ar       <= '0;
    end else if (w_hs0 | w_hs1) begin
      r_ar_valid <= 1'b1;
      r_ar_id    <= w_hs1 ? {1'b1, src1_arid} : {1'b0, src0_arid};
      r_ar       <= w_hs1 ? src1_ar : src0_ar;
    end else if (sink_arready) begin
      r_ar_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves only on a completed source handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (w_hs0) begin
      r_last <= 1'b0;
    end else if (w_hs1) begin
      r_last <= 1'b1;
    end
  end

  // Outstanding-burst next state; a simultaneous issue and completion cancel out.
  always_comb begin
    w_out0_d = r_out0;
    w_out1_d = r_out1;
    if (w_hs0 && !w_rdone0) begin
      w_out0_d = r_out0 + CNT_W'(1);
    end else if (!w_hs0 && w_rdone0 && (r_out0 != '0)) begin
      w_out0_d = r_out0 - CNT_W'(1);
    end
    if (w_hs1 && !w_rdone1) begin
      w_out1_d = r_out1 + CNT_W'(1);
    end else if (!w_hs1 && w_rdone1 && (r_out1 != '0)) begin
      w_out1_d = r_out1 - CNT_W'(1);
    end
  end

  // Outstanding-burst counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out0 <= '0;
      r_out1 <= '0;
    end else begin
      r_out0 <= w_out0_d;
      r_out1 <= w_out1_d;
    end
  end

`ifdef OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN
  logic [31:0] r_stat0, r_stat1;

  // Saturating grant counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else begin
      if (w_hs0 && (r_stat0 != 32'hFFFF_FFFF)) r_stat0 <= r_stat0 + 32'd1;
      if (w_hs1 && (r_stat1 != 32'hFFFF_FFFF)) r_stat1 <= r_stat1 + 32'd1;
    end
  end

  assign stat_grants0 = r_stat0;
  assign stat_grants1 = r_stat1;
`else
  assign stat_grants0 = 32'd0;
  assign stat_grants1 = 32'd0;
`endif

endmodule

// File: tb/tb_ofs_plat_axi_mem_rd_arb2.sv
// Bench for ofs_plat_axi_mem_rd_arb2: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ofs_plat_axi_mem_rd_arb2;
  localparam int unsigned ID_W = 4;
  localparam int unsigned AR_W = 64;
  localparam int unsigned R_W  = 514;
  localparam int          MAXO = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            src0_arvalid, src0_arready, src0_rvalid, src0_rlast, src0_rready;
  logic [ID_W-1:0] src0_arid, src0_rid;
  logic [AR_W-1:0] src0_ar;
  logic [R_W-1:0]  src0_r;
  logic            src1_arvalid, src1_arready, src1_rvalid, src1_rlast, src1_rready;
  logic [ID_W-1:0] src1_arid, src1_rid;
  logic [AR_W-1:0] src1_ar;
  logic [R_W-1:0]  src1_r;
  logic            sink_arvalid, sink_arready, sink_rvalid, sink_rlast, sink_rready;
  logic [ID_W:0]   sink_arid, sink_rid;
  logic [AR_W-1:0] sink_ar;
  logic [R_W-1:0]  sink_r;
  logic [31:0]     stat_grants0, stat_grants1;

  int n_tests = 0;
  int n_fail  = 0;

  ofs_plat_axi_mem_rd_arb2 #(
    .ID_W(ID_W), .AR_W(AR_W), .R_W(R_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .src0_arvalid(src0_arvalid), .src0_arready(src0_arready), .src0_arid(src0_arid),
    .src0_ar(src0_ar), .src0_rvalid(src0_rvalid), .src0_rlast(src0_rlast),
    .src0_rready(src0_rready), .src0_rid(src0_rid), .src0_r(src0_r),
    .src1_arvalid(src1_arvalid), .src1_arready(src1_arready), .src1_arid(src1_arid),
    .src1_ar(src1_ar), .src1_rvalid(src1_rvalid), .src1_rlast(src1_rlast),
    .src1_rready(src1_rready), .src1_rid(src1_rid), .src1_r(src1_r),
    .sink_arvalid(sink_arvalid), .sink_arready(sink_arready), .sink_arid(sink_arid),
    .sink_ar(sink_ar), .sink_rvalid(sink_rvalid), .sink_rlast(sink_rlast),
    .sink_rready(sink_rready), .sink_rid(sink_rid), .sink_r(sink_r),
    .stat_grants0(stat_grants0), .stat_grants1(stat_grants1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- transaction-level model ----------------
  int              m_out [2];
  int              m_last;
  int              m_gr  [2];
  logic [ID_W:0]   m_q_id [$];
  logic [AR_W-1:0] m_q_ar [$];

  always @(negedge clk) begin : model
    logic can_load, e0, e1, g0, g1, rd0, rd1, exp_rr;
    int   win;
    if (!reset_n) begin
      m_out[0] = 0; m_out[1] = 0; m_gr[0] = 0; m_gr[1] = 0; m_last = 1;
      m_q_id.delete(); m_q_ar.delete();
      chk("rst_sink_arvalid", sink_arvalid, 0);
      chk("rst_arready0", src0_arready, 0);
      chk("rst_arready1", src1_arready, 0);
      chk("rst_stat0", stat_grants0, 0);
      chk("rst_stat1", stat_grants1, 0);
    end else begin
      e0 = src0_arvalid && (m_out[0] < MAXO);
      e1 = src1_arvalid && (m_out[1] < MAXO);
      if (e0 && e1) win = (m_last == 0) ? 1 : 0;
      else          win = e1 ? 1 : 0;
      can_load = (m_q_id.size() == 0) || sink_arready;
      g0 = e0 && can_load && (win == 0);
      g1 = e1 && can_load && (win == 1);
      exp_rr = sink_rid[ID_W] ? src1_rready : src0_rready;

      chk("m_sink_arvalid", sink_arvalid, m_q_id.size() != 0);
      if (m_q_id.size() != 0) begin
        chk("m_sink_arid", sink_arid, m_q_id[0]);
        chk("m_sink_ar", sink_ar, m_q_ar[0]);
      end
      chk("m_arready0", src0_arready, g0);
      chk("m_arready1", src1_arready, g1);
      chk("m_rvalid0", src0_rvalid, sink_rvalid && !sink_rid[ID_W]);
      chk("m_rvalid1", src1_rvalid, sink_rvalid && sink_rid[ID_W]);
      chk("m_sink_rready", sink_rready, exp_rr);
      if (sink_rvalid) begin
        if (sink_rid[ID_W]) begin
          chk("m_rid1", src1_rid, sink_rid[ID_W-1:0]);
          chk("m_r1", src1_r, sink_r);
          chk("m_rlast1", src1_rlast, sink_rlast);
        end else begin
          chk("m_rid0", src0_rid, sink_rid[ID_W-1:0]);
          chk("m_r0", src0_r, sink_r);
          chk("m_rlast0", src0_rlast, sink_rlast);
        end
      end
`ifdef OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN
      chk("m_stat0", stat_grants0, 32'(m_gr[0]));
      chk("m_stat1", stat_grants1, 32'(m_gr[1]));
`else
      chk("m_stat0", stat_grants0, 0);
      chk("m_stat1", stat_grants1, 0);
`endif
      // Advance model to the state after the coming rising edge.
      rd0 = sink_rvalid && exp_rr && sink_rlast && !sink_rid[ID_W];
      rd1 = sink_rvalid && exp_rr && sink_rlast && sink_rid[ID_W];
      if ((m_q_id.size() != 0) && sink_arready) begin
        void'(m_q_id.pop_front());
        void'(m_q_ar.pop_front());
      end
      if (g0) begin
        m_q_id.push_back({1'b0, src0_arid}); m_q_ar.push_back(src0_ar);
        m_last = 0; m_gr[0]++;
      end
      if (g1) begin
        m_q_id.push_back({1'b1, src1_arid}); m_q_ar.push_back(src1_ar);
        m_last = 1; m_gr[1]++;
      end
      m_out[0] = m_out[0] + int'(g0) - int'(rd0);
      m_out[1] = m_out[1] + int'(g1) - int'(rd1);
    end
  end

  // One R beat for source s, then idle.
  task automatic r_beat(input logic s, input logic last);
    sink_rvalid = 1'b1;
    sink_rid    = {s, 4'h0};
    sink_rlast  = last;
    sink_r      = R_W'({$urandom, $urandom});
    cyc();
    sink_rvalid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic msb [4];
    int   cnt;
    reset_n = 1'b0;
    src0_arvalid = 0; src0_arid = '0; src0_ar = '0; src0_rready = 1;
    src1_arvalid = 0; src1_arid = '0; src1_ar = '0; src1_rready = 1;
    sink_arready = 0; sink_rvalid = 0; sink_rlast = 0; sink_rid = '0; sink_r = '0;
    #1 chk("lit_reset_arvalid", sink_arvalid, 0);
    cyc(); cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Both sources valid, sink always ready: grants alternate starting with 0.
    src0_arvalid = 1; src0_arid = 4'h1; src0_ar = 64'hA0A0_0000_0000_0001;
    src1_arvalid = 1; src1_arid = 4'h2; src1_ar = 64'hB1B1_0000_0000_0002;
    sink_arready = 1;
    #1;
    chk("lit_first_gnt0", src0_arready, 1);
    chk("lit_first_gnt1", src1_arready, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1 msb[i] = sink_arid[ID_W];
      chk("lit_alt_valid", sink_arvalid, 1);
    end
    chk("lit_alt0", msb[0], 0);
    chk("lit_alt1", msb[1], 1);
    chk("lit_alt2", msb[2], 0);
    chk("lit_alt3", msb[3], 1);
    src0_arvalid = 0; src1_arvalid = 0;
    cyc();
    r_beat(0, 0); r_beat(0, 1); r_beat(0, 0); r_beat(0, 1);
    r_beat(1, 0); r_beat(1, 1); r_beat(1, 0); r_beat(1, 1);

    // Sink stalls with the register full: payload holds, no source accepted.
    sink_arready = 0;
    src0_arvalid = 1; src0_arid = 4'h5; src0_ar = 64'h1111_2222_3333_4444;
    cyc();
    src0_ar = 64'h5555_6666_7777_8888;
    src1_arvalid = 1; src1_arid = 4'h6;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lit_stall_valid", sink_arvalid, 1);
      chk("lit_stall_ar", sink_ar, 64'h1111_2222_3333_4444);
      chk("lit_stall_rdy0", src0_arready, 0);
      chk("lit_stall_rdy1", src1_arready, 0);
      cyc();
    end
    sink_arready = 1;
    #1 chk("lit_release_rdy1", src1_arready, 1);
    cyc();
    src0_arvalid = 0; src1_arvalid = 0;
    cyc();
    r_beat(0, 1); r_beat(1, 1);

    // Outstanding limit on source 0 does not block source 1.
    src0_arvalid = 1; src0_arid = 4'h7;
    for (int i = 0; i < MAXO; i++) cyc();
    src1_arvalid = 1;
    #1;
    chk("lit_limit_rdy0", src0_arready, 0);
    chk("lit_limit_rdy1", src1_arready, 1);
    cyc();
    src1_arvalid = 0;
    sink_rvalid = 1; sink_rid = {1'b0, 4'h7}; sink_rlast = 1;
    #1 chk("lit_limit_still0", src0_arready, 0);
    cyc();
    sink_rvalid = 0;
    #1 chk("lit_limit_freed", src0_arready, 1);
    src0_arvalid = 0;

    // R routing to source 1 with back-pressure.
    sink_rvalid = 1; sink_rid = {1'b1, 4'h3}; sink_rlast = 1; sink_r = R_W'(64'hFEED);
    src1_rready = 0;
    #1;
    chk("lit_r_vld1", src1_rvalid, 1);
    chk("lit_r_rid1", src1_rid, 4'h3);
    chk("lit_r_vld0", src0_rvalid, 0);
    chk("lit_r_rready0", sink_rready, 0);
    cyc();
    src1_rready = 1;
    #1 chk("lit_r_rready1", sink_rready, 1);
    cyc();
    sink_rvalid = 0;
    r_beat(0, 1); r_beat(0, 1); r_beat(0, 1);

    // Same-cycle issue and completion leave the count at 1: exactly 3 more fit.
    src0_arvalid = 1; src0_arid = 4'h9;
    cyc();
    sink_rvalid = 1; sink_rid = {1'b0, 4'h9}; sink_rlast = 1; src0_rready = 1;
    #1 chk("lit_same_rdy", src0_arready, 1);
    cyc();
    sink_rvalid = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (src0_arready) cnt++;
      cyc();
    end
    chk("lit_same_cnt", cnt, 3);
    src0_arvalid = 0;
    r_beat(0, 1); r_beat(0, 1); r_beat(0, 1); r_beat(0, 1);

    // Ten source-0 grants, then reset asserted mid-burst.
    reset_n = 0;
    cyc(); cyc();
    reset_n = 1;
    cyc();
    src0_arvalid = 1; src0_arid = 4'hC;
    cyc();
    sink_rvalid = 1; sink_rid = {1'b0, 4'hC}; sink_rlast = 1;
    for (int i = 0; i < 9; i++) cyc();
    #1;
`ifdef OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN
    chk("lit_stat10", stat_grants0, 10);
`else
    chk("lit_stat_tied", stat_grants0, 0);
`endif
    chk("lit_pre_rst_valid", sink_arvalid, 1);
    reset_n = 0;
    #1;
    chk("lit_rst_stat0", stat_grants0, 0);
    chk("lit_rst_valid", sink_arvalid, 0);
    chk("lit_rst_rdy0", src0_arready, 0);
    sink_rvalid = 0; src0_arvalid = 0;
    cyc(); cyc();
    reset_n = 1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
